// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 key-event sequencer.
// Event word is {ext, brk, code}; FSM folds prefix bytes into one event.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  localparam logic [7:0] DISC_BAT  = 8'hAA;
  localparam logic [7:0] DISC_ACK  = 8'hFA;
  localparam logic [7:0] DISC_RSND = 8'hFE;
  localparam logic [7:0] DISC_ECHO = 8'hEE;
  localparam logic [7:0] DISC_ERR0 = 8'h00;
  localparam logic [7:0] DISC_ERR1 = 8'hFF;

  // Pause is E1 followed by seven trailing bytes that carry no extra information.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == DISC_BAT)  || (b == DISC_ACK)  || (b == DISC_RSND) ||
           (b == DISC_ECHO) || (b == DISC_ERR0) || (b == DISC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; head visible the cycle after the write.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = level_q;
  // Head is forced to zero when empty so stale storage never leaks onto the outputs.
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Folds PS/2 scan-code bytes into {code, break, ext} events, queued and sent valid/ready.
// Event appears one cycle after the final byte; a full queue drops the event and sets OVERFLOW.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          NEW_CODE,
  input  logic [7:0]                    RAW_CODE,
  output logic                          EVT_VALID,
  input  logic                          EVT_READY,
  output logic [7:0]                    EVT_CODE,
  output logic                          EVT_BREAK,
  output logic                          EVT_EXT,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  state_t           state_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [2:0]       skip_cnt_q;
  logic             overflow_q;

  logic             push;
  evt_t             push_evt;
  evt_t             head_evt;
  logic             fifo_empty, fifo_full;
  logic             timeout;

  always_comb begin
    push     = 1'b0;
    push_evt = '0;
    if (NEW_CODE) begin
      case (state_q)
        ST_IDLE: begin
          if (RAW_CODE == PFX_PAUSE) begin
            push     = 1'b1;
            push_evt = '{ext: 1'b0, brk: 1'b0, code: RAW_CODE};
          end else if (RAW_CODE != PFX_EXT && RAW_CODE != PFX_BRK && !is_discard(RAW_CODE)) begin
            push     = 1'b1;
            push_evt = '{ext: 1'b0, brk: 1'b0, code: RAW_CODE};
          end
        end
        ST_EXT: begin
          if (RAW_CODE != PFX_EXT && RAW_CODE != PFX_BRK) begin
            push     = 1'b1;
            push_evt = '{ext: 1'b1, brk: 1'b0, code: RAW_CODE};
          end
        end
        ST_BRK: begin
          push     = 1'b1;
          push_evt = '{ext: 1'b0, brk: 1'b1, code: RAW_CODE};
        end
        ST_EXT_BRK: begin
          push     = 1'b1;
          push_evt = '{ext: 1'b1, brk: 1'b1, code: RAW_CODE};
        end
        default: push = 1'b0;
      endcase
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = (state_q != ST_IDLE) && !NEW_CODE &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      tmo_cnt_q  <= '0;
      skip_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push && fifo_full && !EVT_READY) overflow_q <= 1'b1;

      if (NEW_CODE) begin
        tmo_cnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (RAW_CODE == PFX_EXT) begin
              state_q <= ST_EXT;
            end else if (RAW_CODE == PFX_BRK) begin
              state_q <= ST_BRK;
            end else if (RAW_CODE == PFX_PAUSE) begin
              state_q    <= ST_SKIP;
              skip_cnt_q <= PAUSE_TAIL;
            end
          end
          ST_EXT: begin
            if (RAW_CODE == PFX_BRK)      state_q <= ST_EXT_BRK;
            else if (RAW_CODE != PFX_EXT) state_q <= ST_IDLE;
          end
          ST_SKIP: begin
            skip_cnt_q <= skip_cnt_q - 3'd1;
            if (skip_cnt_q <= 3'd1) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (timeout) begin
        state_q    <= ST_IDLE;
        tmo_cnt_q  <= '0;
        skip_cnt_q <= '0;
      end else if (state_q == ST_IDLE) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (push),
    .pop_i   (EVT_READY),
    .din_i   (push_evt),
    .dout_o  (head_evt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (FIFO_LEVEL)
  );

  assign EVT_VALID = !fifo_empty;
  assign EVT_CODE  = head_evt.code;
  assign EVT_BREAK = head_evt.brk;
  assign EVT_EXT   = head_evt.ext;
  assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl with a short timeout so expiry is reachable.
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       NEW_CODE = 1'b0;
  logic [7:0] RAW_CODE = 8'h00;
  logic       EVT_READY = 1'b0;
  logic       EVT_VALID, EVT_BREAK, EVT_EXT, OVERFLOW;
  logic [7:0] EVT_CODE;
  logic [2:0] FIFO_LEVEL;
  logic [10:0] obs;

  int checks = 0;
  int errors = 0;

  assign obs = {EVT_VALID, EVT_EXT, EVT_BREAK, EVT_CODE};

  ps2_key_event_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (5)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .NEW_CODE   (NEW_CODE),
    .RAW_CODE   (RAW_CODE),
    .EVT_VALID  (EVT_VALID),
    .EVT_READY  (EVT_READY),
    .EVT_CODE   (EVT_CODE),
    .EVT_BREAK  (EVT_BREAK),
    .EVT_EXT    (EVT_EXT),
    .OVERFLOW   (OVERFLOW),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  // All stimulus tasks start and end 1ns after a rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    NEW_CODE = 1'b1;
    RAW_CODE = b;
    step();
    NEW_CODE = 1'b0;
    RAW_CODE = 8'h00;
  endtask

  task automatic pop_one();
    EVT_READY = 1'b1;
    step();
    EVT_READY = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({obs, OVERFLOW, FIFO_LEVEL} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", {obs, OVERFLOW, FIFO_LEVEL}, 15'h0);
    end
    RST = 1'b1;
    step();
  endtask

  task automatic test_make();
    EVT_READY = 1'b1;
    send(8'h1C);
    checks++;
    if (obs !== {3'b100, 8'h1C}) begin
      errors++;
      $display("FAIL make_event got %h exp %h", obs, {3'b100, 8'h1C});
    end
    step();
    checks++;
    if ({EVT_VALID, FIFO_LEVEL} !== 4'h0) begin
      errors++;
      $display("FAIL make_popped got %h exp %h", {EVT_VALID, FIFO_LEVEL}, 4'h0);
    end
    EVT_READY = 1'b0;
  endtask

  task automatic test_break();
    send(8'hF0);
    checks++;
    if (EVT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL break_prefix_only got %b exp 0", EVT_VALID);
    end
    send(8'h1C);
    checks++;
    if ({obs, FIFO_LEVEL} !== {3'b101, 8'h1C, 3'd1}) begin
      errors++;
      $display("FAIL break_event got %h exp %h", {obs, FIFO_LEVEL}, {3'b101, 8'h1C, 3'd1});
    end
    pop_one();
  endtask

  task automatic test_ext();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    checks++;
    if ({obs, FIFO_LEVEL} !== {3'b111, 8'h75, 3'd1}) begin
      errors++;
      $display("FAIL ext_break_event got %h exp %h", {obs, FIFO_LEVEL}, {3'b111, 8'h75, 3'd1});
    end
    pop_one();
    send(8'hE0);
    send(8'h75);
    checks++;
    if ({obs, FIFO_LEVEL} !== {3'b110, 8'h75, 3'd1}) begin
      errors++;
      $display("FAIL ext_make_event got %h exp %h", {obs, FIFO_LEVEL}, {3'b110, 8'h75, 3'd1});
    end
    pop_one();
  endtask

  task automatic test_pause_and_discard();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send(seq[i]);
    checks++;
    if ({obs, FIFO_LEVEL} !== {3'b100, 8'hE1, 3'd1}) begin
      errors++;
      $display("FAIL pause_single_event got %h exp %h", {obs, FIFO_LEVEL}, {3'b100, 8'hE1, 3'd1});
    end
    pop_one();
    send(8'h1C);
    checks++;
    if ({obs, FIFO_LEVEL} !== {3'b100, 8'h1C, 3'd1}) begin
      errors++;
      $display("FAIL pause_back_idle got %h exp %h", {obs, FIFO_LEVEL}, {3'b100, 8'h1C, 3'd1});
    end
    pop_one();
    send(8'hAA);
    send(8'hFA);
    send(8'h00);
    checks++;
    if ({EVT_VALID, FIFO_LEVEL} !== 4'h0) begin
      errors++;
      $display("FAIL discard_bytes got %h exp %h", {EVT_VALID, FIFO_LEVEL}, 4'h0);
    end
  endtask

  task automatic test_timeout();
    send(8'hE0);
    repeat (TMO) step();
    send(8'h1C);
    checks++;
    if (obs !== {3'b100, 8'h1C}) begin
      errors++;
      $display("FAIL timeout_clears_ext got %h exp %h", obs, {3'b100, 8'h1C});
    end
    pop_one();
    send(8'hE0);
    repeat (TMO - 1) step();
    send(8'h1C);
    checks++;
    if (obs !== {3'b110, 8'h1C}) begin
      errors++;
      $display("FAIL timeout_code_wins got %h exp %h", obs, {3'b110, 8'h1C});
    end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h35};
    logic [7:0] drain [4] = '{8'h1D, 8'h24, 8'h2D, 8'h66};
    for (int i = 0; i < 5; i++) send(codes[i]);
    checks++;
    if ({FIFO_LEVEL, OVERFLOW, obs} !== {3'd4, 1'b1, 3'b100, 8'h15}) begin
      errors++;
      $display("FAIL overflow_full got %h exp %h", {FIFO_LEVEL, OVERFLOW, obs}, {3'd4, 1'b1, 3'b100, 8'h15});
    end
    EVT_READY = 1'b1;
    send(8'h66);
    EVT_READY = 1'b0;
    checks++;
    if ({FIFO_LEVEL, EVT_CODE} !== {3'd4, 8'h1D}) begin
      errors++;
      $display("FAIL full_push_pop got %h exp %h", {FIFO_LEVEL, EVT_CODE}, {3'd4, 8'h1D});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== {3'b100, drain[i]}) begin
        errors++;
        $display("FAIL drain_order idx %0d got %h exp %h", i, obs, {3'b100, drain[i]});
      end
      pop_one();
    end
    checks++;
    if ({EVT_VALID, FIFO_LEVEL, OVERFLOW} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL drain_empty_sticky got %h exp %h", {EVT_VALID, FIFO_LEVEL, OVERFLOW}, {1'b0, 3'd0, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    EVT_READY = 1'b1;
    NEW_CODE  = 1'b1;
    RAW_CODE  = 8'h16;
    step();
    checks++;
    if (obs !== {3'b100, 8'h16}) begin
      errors++;
      $display("FAIL b2b_first got %h exp %h", obs, {3'b100, 8'h16});
    end
    RAW_CODE = 8'h1E;
    step();
    NEW_CODE  = 1'b0;
    EVT_READY = 1'b0;
    checks++;
    if ({obs, FIFO_LEVEL} !== {3'b100, 8'h1E, 3'd1}) begin
      errors++;
      $display("FAIL b2b_second got %h exp %h", {obs, FIFO_LEVEL}, {3'b100, 8'h1E, 3'd1});
    end
    pop_one();
  endtask

  task automatic test_async_reset();
    send(8'h15);
    send(8'h1D);
    send(8'hE0);
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({obs, OVERFLOW, FIFO_LEVEL} !== 15'h0) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", {obs, OVERFLOW, FIFO_LEVEL}, 15'h0);
    end
    #3;
    RST = 1'b1;
    step();
    send(8'h1C);
    checks++;
    if ({obs, FIFO_LEVEL} !== {3'b100, 8'h1C, 3'd1}) begin
      errors++;
      $display("FAIL post_reset_make got %h exp %h", {obs, FIFO_LEVEL}, {3'b100, 8'h1C, 3'd1});
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_pause_and_discard();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
